// File: rtl/mavg_rr_scheduler.sv
// mavg_rr_scheduler
//   One 4-tap moving-average datapath shared by N_CH sample sources.
//   A round-robin arbiter grants at most one channel per cycle. Each channel
//   keeps its own 4-entry sample ring, write pointer and fill count. A
//   registered result, tagged with its channel, appears one cycle after the
//   accept once that channel holds 4 samples.
//
//   Optional build macro: MAVG_SCHED_ROUND_EN
//     defined   -> y = (sum + 2) >> 2  (round half up)
//     undefined -> y = sum >> 2        (truncate, default)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high
//   x_is_valid_i [N_CH]   channel i offers a sample
//   x_i          [N_CH*W] channel i sample at x_i[i*W +: W]
//   ch_clear_i   [N_CH]   flush channel i history/count (beats its request)
//   x_ready_o    [N_CH]   one-hot grant, combinational
//   y_o          [OUT_W]  average of the last 4 samples of channel y_ch_o
//   y_ch_o       [3]      channel that produced y_o
//   y_is_valid_o          single-cycle result strobe
module mavg_rr_scheduler #(
  parameter int N_CH  = 4,
  parameter int W     = 4,
  parameter int OUT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   x_is_valid_i,
  input  logic [N_CH*W-1:0] x_i,
  input  logic [N_CH-1:0]   ch_clear_i,
  output logic [N_CH-1:0]   x_ready_o,
  output logic [OUT_W-1:0]  y_o,
  output logic [2:0]        y_ch_o,
  output logic              y_is_valid_o
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0][3:0][W-1:0] ring_q;
  logic [N_CH-1:0][1:0]        wr_q;
  logic [N_CH-1:0][2:0]        cnt_q;
  logic [PW-1:0]               ptr_q, ptr_d;
  logic [OUT_W-1:0]            y_q, y_d;
  logic [2:0]                  y_ch_q;
  logic                        y_vld_q, y_vld_d;

  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] grant;
  logic [PW-1:0]   gidx;
  logic            found;
  int              idx;

  // A cleared channel is never eligible, so its request is neither granted
  // nor consumed in the clear cycle.
  assign elig = x_is_valid_i & ~ch_clear_i;

  // Rotating priority search starting at ptr.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    grant = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr_q) + k) % N_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = idx[PW-1:0];
      end
    end
    grant[gidx] = found;
  end

  assign x_ready_o = grant;

  // Shared datapath operating on the granted channel.
  logic [W-1:0]   xs, r1, r2, r3;
  logic [1:0]     wr_g, s1, s2, s3;
  logic [W+1:0]   sum;
  logic [W-1:0]   avg;

  always_comb begin
    xs   = x_i[gidx*W +: W];
    wr_g = wr_q[gidx];
    // Slot wr is the oldest entry and gets overwritten; the other three are
    // the previous samples that join the new one in the sum.
    s1   = wr_g + 2'd1;
    s2   = wr_g + 2'd2;
    s3   = wr_g + 2'd3;
    r1   = ring_q[gidx][s1];
    r2   = ring_q[gidx][s2];
    r3   = ring_q[gidx][s3];
    sum  = {2'b00, xs} + {2'b00, r1} + {2'b00, r2} + {2'b00, r3};
`ifdef MAVG_SCHED_ROUND_EN
    avg  = W'((sum + (W+2)'(2)) >> 2);
`else
    avg  = W'(sum >> 2);
`endif
    // Result is valid once the post-accept count reaches 4.
    y_vld_d = found && (cnt_q[gidx] >= 3'd3);
    y_d     = y_vld_d ? OUT_W'(avg) : y_q;
    if (!found)
      ptr_d = ptr_q;
    else if (gidx == PW'(N_CH-1))
      ptr_d = '0;
    else
      ptr_d = gidx + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q  <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      y_q     <= '0;
      y_ch_q  <= '0;
      y_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_clear_i[i]) begin
          ring_q[i] <= '0;
          wr_q[i]   <= '0;
          cnt_q[i]  <= '0;
        end else if (grant[i]) begin
          ring_q[i][wr_q[i]] <= xs;
          wr_q[i]            <= wr_q[i] + 2'd1;
          if (cnt_q[i] != 3'd4) cnt_q[i] <= cnt_q[i] + 3'd1;
        end
      end
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
      if (y_vld_d) y_ch_q <= 3'(gidx);
    end
  end

  assign y_o          = y_q;
  assign y_ch_o       = y_ch_q;
  assign y_is_valid_o = y_vld_q;

endmodule

// File: tb/tb_mavg_rr_scheduler.sv
module tb_mavg_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  x_is_valid;
  logic [15:0] x;
  logic [3:0]  ch_clear;
  logic [3:0]  x_ready;
  logic [5:0]  y;
  logic [2:0]  y_ch;
  logic        y_is_valid;

  int n_chk = 0;
  int n_err = 0;

`ifdef MAVG_SCHED_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  always #5 clk = ~clk;

  mavg_rr_scheduler #(.N_CH(4), .W(4), .OUT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .x_is_valid_i (x_is_valid),
    .x_i          (x),
    .ch_clear_i   (ch_clear),
    .x_ready_o    (x_ready),
    .y_o          (y),
    .y_ch_o       (y_ch),
    .y_is_valid_o (y_is_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; x_is_valid = '0; x = '0; ch_clear = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // One accept cycle: drive, check grant before the edge, check the result after.
  task automatic feed(input string tag, input logic [3:0] v, input logic [3:0] clr,
                      input logic [15:0] xd, input logic [3:0] exp_rdy,
                      input logic exp_vld, input logic [5:0] exp_y, input logic [2:0] exp_ch);
    x_is_valid = v; ch_clear = clr; x = xd;
    #1;
    chk({tag, ".rdy"}, 32'(x_ready), 32'(exp_rdy));
    cyc();
    chk({tag, ".vld"}, 32'(y_is_valid), 32'(exp_vld));
    if (exp_vld) begin
      chk({tag, ".y"},  32'(y),    32'(exp_y));
      chk({tag, ".ch"}, 32'(y_ch), 32'(exp_ch));
    end
    x_is_valid = '0; ch_clear = '0;
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst.y",   32'(y), 0);
    chk("rst.ch",  32'(y_ch), 0);
    chk("rst.vld", 32'(y_is_valid), 0);
    chk("rst.rdy_idle", 32'(x_ready), 0);

    // 1: ch0 samples 3..8
    feed("t1.s3", 4'b0001, 4'b0, 16'h0003, 4'b0001, 1'b0, 0, 0);
    feed("t1.s4", 4'b0001, 4'b0, 16'h0004, 4'b0001, 1'b0, 0, 0);
    feed("t1.s5", 4'b0001, 4'b0, 16'h0005, 4'b0001, 1'b0, 0, 0);
    feed("t1.s6", 4'b0001, 4'b0, 16'h0006, 4'b0001, 1'b1, RND ? 6'd5 : 6'd4, 0);
    feed("t1.s7", 4'b0001, 4'b0, 16'h0007, 4'b0001, 1'b1, RND ? 6'd6 : 6'd5, 0);
    feed("t1.s8", 4'b0001, 4'b0, 16'h0008, 4'b0001, 1'b1, RND ? 6'd7 : 6'd6, 0);

    // 2: all channels valid every cycle, channel i sends i+1
    do_reset();
    for (int k = 0; k < 16; k++) begin
      logic [3:0] er;
      er = 4'b0001 << (k % 4);
      feed($sformatf("t2.k%0d", k), 4'b1111, 4'b0, 16'h4321, er,
           (k >= 12), 6'((k % 4) + 1), 3'(k % 4));
    end

    // 3: ptr=2 with ch1/ch3 requesting; ch1 fed 15s
    do_reset();
    feed("t3.setup", 4'b0010, 4'b0, 16'h00F0, 4'b0010, 1'b0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      logic [3:0] er;
      er = (k % 2 == 0) ? 4'b1000 : 4'b0010;
      feed($sformatf("t3.k%0d", k), 4'b1010, 4'b0, 16'h50F0, er, (k == 5), 6'd15, 3'd1);
    end

    // 4: ch2 filled with 8s, then cleared with a same-cycle request
    do_reset();
    for (int k = 0; k < 4; k++)
      feed($sformatf("t4.f%0d", k), 4'b0100, 4'b0, 16'h0800, 4'b0100, (k == 3), 6'd8, 3'd2);
    feed("t4.clr", 4'b0101, 4'b0100, 16'h0801, 4'b0001, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++)
      feed($sformatf("t4.n%0d", k), 4'b0100, 4'b0, 16'h0400, 4'b0100, (k == 3), 6'd4, 3'd2);

    // 5: reset mid-stream with ch0 full
    do_reset();
    for (int k = 0; k < 4; k++)
      feed($sformatf("t5.f%0d", k), 4'b0001, 4'b0, 16'h0008, 4'b0001, (k == 3), 6'd8, 3'd0);
    x_is_valid = 4'b0001; x = 16'h0008; rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5.rst.y",   32'(y), 0);
    chk("t5.rst.vld", 32'(y_is_valid), 0);
    // ptr must be back at 0: with ch0/ch1 requesting, ch0 wins
    feed("t5.p0", 4'b0011, 4'b0, 16'h0088, 4'b0001, 1'b0, 0, 0);
    feed("t5.a1", 4'b0001, 4'b0, 16'h0008, 4'b0001, 1'b0, 0, 0);
    feed("t5.a2", 4'b0001, 4'b0, 16'h0008, 4'b0001, 1'b0, 0, 0);
    feed("t5.a3", 4'b0001, 4'b0, 16'h0008, 4'b0001, 1'b1, 6'd8, 3'd0);

    // 6: ch0 1,2,2,2 -> sum 7
    do_reset();
    feed("t6.a0", 4'b0001, 4'b0, 16'h0001, 4'b0001, 1'b0, 0, 0);
    feed("t6.a1", 4'b0001, 4'b0, 16'h0002, 4'b0001, 1'b0, 0, 0);
    feed("t6.a2", 4'b0001, 4'b0, 16'h0002, 4'b0001, 1'b0, 0, 0);
    feed("t6.a3", 4'b0001, 4'b0, 16'h0002, 4'b0001, 1'b1, RND ? 6'd2 : 6'd1, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
